// File: rtl/ps2_mouse_rx.sv
// rtl/ps2_mouse_rx.sv - receive-only PS/2 mouse front end producing the mouseInfo word
//
// Purpose: deserialises 11-bit device-to-host PS/2 frames, assembles 3-byte
// stream-mode packets and publishes each one atomically as
// {seq, status, dx, dy}. Framing, parity, sync and timeout errors drop the
// byte or partial packet and realign on the next status byte.
//
// Ports:
//   clk        in   1   system clock (single domain)
//   rst        in   1   asynchronous active-low reset
//   ps2_clk    in   1   raw PS/2 clock pin (asynchronous)
//   ps2_data   in   1   raw PS/2 data pin (asynchronous)
//   mouseInfo  out  32  {seq, status, dx, dy} of the last good packet
//   pkt_valid  out  1   one-cycle pulse coincident with a mouseInfo update
//   frame_err  out  1   one-cycle pulse on any discarded byte or packet
//   err_cnt    out  8   saturating count of frame_err pulses
module ps2_mouse_rx #(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [31:0] mouseInfo,
  output logic        pkt_valid,
  output logic        frame_err,
  output logic [7:0]  err_cnt
);

  localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_t;

  // Synchronisers, preset to the idle-high line level.
  logic r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;

  // Clock stability filter.
  logic [FW-1:0] r_flt_cnt;
  logic          r_clk_flt;
  logic          r_clk_flt_d;
  logic          w_strobe;

  // Frame FSM and shifter.
  state_t      r_state, w_state_nxt;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift;
  logic        r_par;
  logic        w_byte_ok;
  logic        w_byte_bad;

  // Timeout.
  logic [TW-1:0] r_to_cnt;
  logic          w_busy;
  logic          w_timeout;

  // Packet assembly.
  logic [1:0]  r_idx;
  logic [7:0]  r_status;
  logic [7:0]  r_dx;
  logic [31:0] r_info;
  logic        r_pkt_valid;
  logic        r_frame_err;
  logic [7:0]  r_err_cnt;
  logic        w_lead_bad;
  logic        w_pkt_done;
  logic        w_err;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clk_s1 <= 1'b1;
      r_clk_s2 <= 1'b1;
      r_dat_s1 <= 1'b1;
      r_dat_s2 <= 1'b1;
    end else begin
      r_clk_s1 <= ps2_clk;
      r_clk_s2 <= r_clk_s1;
      r_dat_s1 <= ps2_data;
      r_dat_s2 <= r_dat_s1;
    end
  end

  // The filtered clock follows the synchronised clock only after it has
  // disagreed for FILTER_LEN consecutive cycles; shorter glitches reset the run.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_flt_cnt   <= '0;
      r_clk_flt   <= 1'b1;
      r_clk_flt_d <= 1'b1;
    end else begin
      r_clk_flt_d <= r_clk_flt;
      if (r_clk_s2 != r_clk_flt) begin
        if (r_flt_cnt == FW'(FILTER_LEN - 1)) begin
          r_clk_flt <= r_clk_s2;
          r_flt_cnt <= '0;
        end else begin
          r_flt_cnt <= r_flt_cnt + FW'(1);
        end
      end else begin
        r_flt_cnt <= '0;
      end
    end
  end

  assign w_strobe = r_clk_flt_d & ~r_clk_flt;

  // Timeout is only armed mid-frame or mid-packet; a strobe in the same
  // cycle takes priority and restarts the count.
  assign w_busy    = (r_state != S_IDLE) || (r_idx != 2'd0);
  assign w_timeout = !w_strobe && w_busy && (r_to_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_to_cnt <= '0;
    end else if (w_strobe || !w_busy || w_timeout) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= r_to_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_byte_ok   = 1'b0;
    w_byte_bad  = 1'b0;
    if (w_strobe) begin
      case (r_state)
        S_IDLE:   if (!r_dat_s2) w_state_nxt = S_DATA;
        S_DATA:   if (r_bit_cnt == 3'd7) w_state_nxt = S_PARITY;
        S_PARITY: w_state_nxt = S_STOP;
        S_STOP: begin
          w_state_nxt = S_IDLE;
          // Odd parity over data + parity bit, and a high stop bit.
          if (r_dat_s2 && (^{r_par, r_shift})) begin
            w_byte_ok = 1'b1;
          end else begin
            w_byte_bad = 1'b1;
          end
        end
        default:  w_state_nxt = S_IDLE;
      endcase
    end else if (w_timeout) begin
      w_state_nxt = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bit_cnt <= 3'd0;
      r_shift   <= 8'd0;
      r_par     <= 1'b0;
    end else if (w_strobe) begin
      case (r_state)
        S_IDLE: r_bit_cnt <= 3'd0;
        S_DATA: begin
          r_shift   <= {r_dat_s2, r_shift[7:1]};
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end
        S_PARITY: r_par <= r_dat_s2;
        default: ;
      endcase
    end
  end

  // A status byte must carry the always-one bit 3; anything else at index 0
  // is treated as misalignment and discarded.
  assign w_lead_bad = w_byte_ok && (r_idx == 2'd0) && !r_shift[3];
  assign w_pkt_done = w_byte_ok && (r_idx == 2'd2);
  assign w_err      = w_byte_bad || w_lead_bad || w_timeout;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_idx       <= 2'd0;
      r_status    <= 8'd0;
      r_dx        <= 8'd0;
      r_info      <= 32'd0;
      r_pkt_valid <= 1'b0;
      r_frame_err <= 1'b0;
      r_err_cnt   <= 8'd0;
    end else begin
      r_pkt_valid <= w_pkt_done;
      r_frame_err <= w_err;
      if (w_err && (r_err_cnt != 8'hFF)) begin
        r_err_cnt <= r_err_cnt + 8'd1;
      end
      if (w_err) begin
        r_idx <= 2'd0;
      end else if (w_byte_ok) begin
        case (r_idx)
          2'd0: begin
            r_status <= r_shift;
            r_idx    <= 2'd1;
          end
          2'd1: begin
            r_dx  <= r_shift;
            r_idx <= 2'd2;
          end
          default: begin
            // dy comes straight from the shifter so the word updates in one step.
            r_info <= {r_info[31:24] + 8'd1, r_status, r_dx, r_shift};
            r_idx  <= 2'd0;
          end
        endcase
      end
    end
  end

  assign mouseInfo = r_info;
  assign pkt_valid = r_pkt_valid;
  assign frame_err = r_frame_err;
  assign err_cnt   = r_err_cnt;

endmodule
